// File: rtl/button_conditioner.sv
// button_conditioner: per-button 2-flop synchroniser, debouncer, press-edge strobe and auto-repeat.
// Produces one BTN_PULSE per accepted press and per repeat interval while a repeat-enabled button is held.
module button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_RATE     = 100000
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [N_BTN-1:0] BTN_RAW,
    input  logic [N_BTN-1:0] REPEAT_EN,
    output logic [N_BTN-1:0] BTN_PULSE,
    output logic [N_BTN-1:0] BTN_LEVEL,
    output logic [N_BTN-1:0] BTN_HELD
);

    localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_P = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
    localparam int CW    = $clog2(MAX_P);

    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        REPEAT
    } state_t;

    logic [N_BTN-1:0] sync_meta;
    logic [N_BTN-1:0] sync_q;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= BTN_RAW;
            sync_q    <= sync_meta;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [CW-1:0] db_cnt, db_cnt_next;
        logic [CW-1:0] rpt_cnt, rpt_cnt_next;
        logic          level_q, level_next;
        logic          pulse_q, pulse_next;
        logic          held_q, held_next;
        state_t        state, state_next;

        // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_comb begin
            db_cnt_next = '0;
            level_next  = level_q;
            if (sync_q[i] != level_q) begin
                if (db_cnt == DB_LAST) begin
                    level_next = ~level_q;
                end else begin
                    db_cnt_next = db_cnt + CW'(1);
                end
            end
        end

        // The FSM watches level_next so the press strobe lands on the same edge the level rises.
        always_comb begin
            state_next   = state;
            rpt_cnt_next = rpt_cnt;
            pulse_next   = 1'b0;
            held_next    = held_q;
            case (state)
                IDLE: begin
                    rpt_cnt_next = '0;
                    held_next    = 1'b0;
                    if (level_next && !level_q) begin
                        pulse_next = 1'b1;
                        state_next = PRESSED;
                    end
                end
                PRESSED: begin
                    held_next = 1'b0;
                    if (!level_next) begin
                        rpt_cnt_next = '0;
                        state_next   = IDLE;
                    end else if (!REPEAT_EN[i]) begin
                        rpt_cnt_next = '0;
                    end else if (rpt_cnt == DELAY_LAST) begin
                        pulse_next   = 1'b1;
                        rpt_cnt_next = '0;
                        held_next    = 1'b1;
                        state_next   = REPEAT;
                    end else begin
                        rpt_cnt_next = rpt_cnt + CW'(1);
                    end
                end
                REPEAT: begin
                    if (!level_next) begin
                        held_next    = 1'b0;
                        rpt_cnt_next = '0;
                        state_next   = IDLE;
                    end else if (!REPEAT_EN[i]) begin
                        held_next    = 1'b0;
                        rpt_cnt_next = '0;
                        state_next   = PRESSED;
                    end else if (rpt_cnt == RATE_LAST) begin
                        pulse_next   = 1'b1;
                        rpt_cnt_next = '0;
                    end else begin
                        rpt_cnt_next = rpt_cnt + CW'(1);
                    end
                end
                default: begin
                    rpt_cnt_next = '0;
                    held_next    = 1'b0;
                    state_next   = IDLE;
                end
            endcase
        end

        always_ff @(posedge CLK) begin
            if (!RESETN) begin
                state   <= IDLE;
                db_cnt  <= '0;
                rpt_cnt <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
                held_q  <= 1'b0;
            end else begin
                state   <= state_next;
                db_cnt  <= db_cnt_next;
                rpt_cnt <= rpt_cnt_next;
                level_q <= level_next;
                pulse_q <= pulse_next;
                held_q  <= held_next;
            end
        end

        assign BTN_PULSE[i] = pulse_q;
        assign BTN_LEVEL[i] = level_q;
        assign BTN_HELD[i]  = held_q;
    end

endmodule
